// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter: shares one wishbone-style memory port between the
// instruction-fetch master (read-only) and the load/store master (read/write).
// One transaction is outstanding at a time, and the grant is held until mem_ack.
// The data side has priority. A starvation counter forces an instruction grant
// after STARVE_LIMIT consecutive instruction losses.
// Optional feature: define KRONOS_ARB_TIMEOUT_EN to enable a bus-timeout error-ack
// after TIMEOUT_CYCLES owned cycles without mem_ack.
module kronos_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_we,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       timeout;
  logic       both_req;

  assign both_req = instr_req && data_req;

`ifdef KRONOS_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;

  // Wait counter: held at 0 in IDLE, counts owned cycles that pass without mem_ack.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz)                wait_cnt <= '0;
    else if (state == IDLE)   wait_cnt <= '0;
    else if (!mem_ack)        wait_cnt <= wait_cnt + 16'd1;
  end

  // A real mem_ack in the last allowed cycle wins over the timeout.
  assign timeout = (state != IDLE) && !mem_ack && (wait_cnt == WAIT_LAST);
`else
  logic unused_timeout_cfg;

  // TIMEOUT_CYCLES only matters when the timeout feature is built in.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  assign bus_err = timeout;

  // State and starvation-counter registers; reset abandons any in-flight bus cycle.
  always_ff @(posedge clk or negedge rstz) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    if (!rstz) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Arbitration, owner muxing of the bus, and ack/read-data routing.
  always_comb begin
    // NOTE: every output is given a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    mem_req      = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    mem_mask     = '0;
    mem_we       = 1'b0;
    instr_ack    = 1'b0;
    instr_data   = '0;
    data_ack     = 1'b0;
    data_rd_data = '0;

    case (state)
      IDLE: begin
        if (data_req && !(both_req && starve_cnt == LIMIT)) begin
          state_nxt = DATA;
          // A data win over a waiting fetch is one more instruction loss.
          // It cannot pass LIMIT because at LIMIT the fetch wins instead.
          if (both_req) starve_nxt = starve_cnt + 4'd1;
        end else if (instr_req) begin
          state_nxt  = INSTR;
          starve_nxt = '0;
        end
      end

      INSTR: begin
        mem_req  = 1'b1;
        mem_addr = instr_addr;
        mem_mask = 4'hF;
        if (mem_ack) begin
          instr_ack  = 1'b1;
          instr_data = mem_rd_data;
          state_nxt  = IDLE;
        end else if (timeout) begin
          instr_ack = 1'b1;
          state_nxt = IDLE;
        end
      end

      DATA: begin
        mem_req     = 1'b1;
        mem_addr    = data_addr;
        mem_wr_data = data_wr_data;
        mem_mask    = data_mask;
        mem_we      = data_we;
        if (mem_ack) begin
          data_ack     = 1'b1;
          data_rd_data = mem_rd_data;
          state_nxt    = IDLE;
        end else if (timeout) begin
          data_ack  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Testbench for kronos_mem_arbiter.
// It replays a table of per-cycle vectors with hand-computed expectations, then
// runs hand-written sequences for starvation, async reset and timeout behaviour.
// The timeout sequences are built in only with KRONOS_ARB_TIMEOUT_EN.
module tb_kronos_mem_arbiter;

  localparam logic [31:0] IADDR = 32'h0000_0100;
  localparam logic [31:0] DADDR = 32'h0000_2004;
  localparam logic [31:0] DWDAT = 32'hCAFE_F00D;
  localparam logic [3:0]  DMASK = 4'hC;

  logic        clk = 1'b0;
  logic        rstz;
  logic        instr_req, instr_ack;
  logic [31:0] instr_addr, instr_data;
  logic        data_req, data_we, data_ack;
  logic [31:0] data_addr, data_wr_data, data_rd_data;
  logic [3:0]  data_mask;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_mask;

  int checks = 0;
  int errors = 0;

  kronos_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rstz         (rstz),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_ack    (instr_ack),
    .instr_data   (instr_data),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_mask    (data_mask),
    .data_we      (data_we),
    .data_ack     (data_ack),
    .data_rd_data (data_rd_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_mask     (mem_mask),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .mem_rd_data  (mem_rd_data),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic        mack;
    logic [31:0] rd;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic        e_iack;
    logic [31:0] e_idata;
    logic        e_dack;
    logic [31:0] e_ddata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector just after the falling edge, then check the combinational outputs.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    instr_req   = v.ireq;
    data_req    = v.dreq;
    data_we     = v.dwe;
    mem_ack     = v.mack;
    mem_rd_data = v.rd;
    #1;
    check($sformatf("v%0d mem_req", idx),      32'(mem_req),    32'(v.e_mreq));
    check($sformatf("v%0d mem_addr", idx),     mem_addr,        v.e_addr);
    check($sformatf("v%0d mem_we", idx),       32'(mem_we),     32'(v.e_we));
    check($sformatf("v%0d mem_mask", idx),     32'(mem_mask),   32'(v.e_mask));
    check($sformatf("v%0d mem_wr_data", idx),  mem_wr_data,     v.e_wdata);
    check($sformatf("v%0d instr_ack", idx),    32'(instr_ack),  32'(v.e_iack));
    check($sformatf("v%0d instr_data", idx),   instr_data,      v.e_idata);
    check($sformatf("v%0d data_ack", idx),     32'(data_ack),   32'(v.e_dack));
    check($sformatf("v%0d data_rd_data", idx), data_rd_data,    v.e_ddata);
    check($sformatf("v%0d bus_err", idx),      32'(bus_err),    32'd0);
  endtask

  initial begin
    //            ireq  dreq  dwe   mack  rd             mreq  addr   we    mask   wdata  iack  idata          dack  ddata
    // Single fetch: arbitration cycle, one wait cycle, then ack with data.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 4'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, IADDR, 1'b0, 4'hF,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF,  1'b1, IADDR, 1'b0, 4'hF,  32'h0, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0};
    // mem_ack while IDLE must be ignored.
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678,  1'b0, 32'h0, 1'b0, 4'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
    // Both masters rise together: the store goes first, then the fetch.
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 4'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, DADDR, 1'b1, DMASK, DWDAT, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00000055,  1'b1, DADDR, 1'b1, DMASK, DWDAT, 1'b0, 32'h0,         1'b1, 32'h00000055};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 4'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5,  1'b1, IADDR, 1'b0, 4'hF,  32'h0, 1'b1, 32'hA5A5A5A5,  1'b0, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 4'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0};

    instr_addr   = IADDR;
    data_addr    = DADDR;
    data_wr_data = DWDAT;
    data_mask    = DMASK;
    instr_req    = 1'b0;
    data_req     = 1'b0;
    data_we      = 1'b0;
    mem_ack      = 1'b0;
    mem_rd_data  = '0;
    rstz         = 1'b0;

    // Reset state: everything quiet even with requests pending.
    #2;
    instr_req = 1'b1;
    data_req  = 1'b1;
    #1;
    check("reset mem_req",   32'(mem_req),   32'd0);
    check("reset mem_addr",  mem_addr,       32'd0);
    check("reset mem_mask",  32'(mem_mask),  32'd0);
    check("reset instr_ack", 32'(instr_ack), 32'd0);
    check("reset data_ack",  32'(data_ack),  32'd0);
    check("reset bus_err",   32'(bus_err),   32'd0);
    @(negedge clk);
    instr_req = 1'b0;
    data_req  = 1'b0;
    rstz      = 1'b1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Starvation: both masters always requesting, immediate ack.
    // The starve count is 0 here, so the grants run D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      instr_req   = 1'b1;
      data_req    = 1'b1;
      data_we     = 1'b0;
      mem_ack     = 1'b1;
      mem_rd_data = 32'h1000 + 32'(k);
      #1;
      check($sformatf("starve%0d idle mem_req", k), 32'(mem_req), 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("starve%0d mem_req", k),   32'(mem_req),   32'd1);
      check($sformatf("starve%0d data_ack", k),  32'(data_ack),  32'((k % 5) != 4));
      check($sformatf("starve%0d instr_ack", k), 32'(instr_ack), 32'((k % 5) == 4));
      check($sformatf("starve%0d mem_addr", k),  mem_addr,       ((k % 5) == 4) ? IADDR : DADDR);
    end
    @(negedge clk);
    instr_req = 1'b0;
    data_req  = 1'b0;
    mem_ack   = 1'b0;

    // Async reset while DATA owns the bus.
    @(negedge clk);
    data_req = 1'b1;
    #1;
    check("rst seq arb mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack     = 1'b1;
    mem_rd_data = 32'h0000_0099;
    #1;
    check("rst seq owned mem_req", 32'(mem_req), 32'd1);
    #1;
    rstz = 1'b0;
    #1;
    check("rst async mem_req",  32'(mem_req),  32'd0);
    check("rst async data_ack", 32'(data_ack), 32'd0);
    check("rst async mem_addr", mem_addr,      32'd0);
    check("rst async rd_data",  data_rd_data,  32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    rstz    = 1'b1;
    #1;
    check("rst release mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1;
    check("rst rearb mem_req",  32'(mem_req), 32'd1);
    check("rst rearb mem_addr", mem_addr,     DADDR);
    @(negedge clk);
    mem_ack     = 1'b1;
    mem_rd_data = 32'h0000_0031;
    #1;
    check("rst rearb data_ack", 32'(data_ack), 32'd1);
    check("rst rearb rd_data",  data_rd_data,  32'h0000_0031);
    @(negedge clk);
    data_req = 1'b0;
    mem_ack  = 1'b0;

`ifdef KRONOS_ARB_TIMEOUT_EN
    // Load with no mem_ack: forced error-ack on the 8th owned cycle.
    @(negedge clk);
    data_req    = 1'b1;
    data_we     = 1'b0;
    mem_rd_data = 32'hBAD0_BAD0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("to c%0d mem_req", c),  32'(mem_req),  32'd1);
      check($sformatf("to c%0d data_ack", c), 32'(data_ack), 32'(c == 8));
      check($sformatf("to c%0d bus_err", c),  32'(bus_err),  32'(c == 8));
      check($sformatf("to c%0d rd_data", c),  data_rd_data,  32'd0);
    end
    @(negedge clk);
    data_req = 1'b0;
    #1;
    check("to after mem_req", 32'(mem_req), 32'd0);

    // Same load, but mem_ack lands in the 8th owned cycle: a normal ack wins.
    @(negedge clk);
    data_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      mem_ack     = (c == 8);
      mem_rd_data = 32'h0000_0077;
      #1;
      check($sformatf("late c%0d data_ack", c), 32'(data_ack), 32'(c == 8));
      check($sformatf("late c%0d bus_err", c),  32'(bus_err),  32'd0);
      check($sformatf("late c%0d rd_data", c),  data_rd_data,  (c == 8) ? 32'h0000_0077 : 32'd0);
    end
    @(negedge clk);
    data_req = 1'b0;
    mem_ack  = 1'b0;
    #1;
    check("late after mem_req", 32'(mem_req), 32'd0);
`else
    // No timeout: the arbiter keeps waiting well past 8 cycles.
    @(negedge clk);
    data_req = 1'b1;
    data_we  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("wait c%0d mem_req", c),  32'(mem_req),  32'd1);
      check($sformatf("wait c%0d data_ack", c), 32'(data_ack), 32'd0);
      check($sformatf("wait c%0d bus_err", c),  32'(bus_err),  32'd0);
    end
    @(negedge clk);
    mem_ack     = 1'b1;
    mem_rd_data = 32'h0000_0123;
    #1;
    check("wait final data_ack", 32'(data_ack), 32'd1);
    check("wait final rd_data",  data_rd_data,  32'h0000_0123);
    @(negedge clk);
    data_req = 1'b0;
    mem_ack  = 1'b0;
    #1;
    check("wait after mem_req", 32'(mem_req), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
